vdp_port_ctrl: RTL and testbench
================================

Name: vdp_port_ctrl

Overview:
- CPU-side port controller for the TMS9918-style VDP: decodes data port (0x98) and control port (0x99) accesses.
- Sequences all CPU accesses to the 16 KB video RAM: address latch, auto-increment, read-ahead buffer.
- Holds VDP registers R0–R7 and drives the mode, table-base and interrupt signals consumed by the video block.
- Sits between the Z80 I/O decode and the VRAM CPU port (port A).

Parameters:
- ADDR_W, 14, VRAM address width; address wraps modulo 2^ADDR_W.
- REG_RESET, 64'h0, reset image of R7..R0; R0 is in bits 7:0.

Ports:
- clk  in  1  system clock (same clock as the VRAM CPU port)
- reset  in  1  synchronous, active-high reset
- io_port  in  1  0 = data port, 1 = control port; sampled with the strobes
- io_wr  in  1  one-cycle write strobe
- io_rd  in  1  one-cycle read strobe
- io_din  in  8  CPU write data
- io_dout  out  8  CPU read data; registered, valid the cycle after io_rd
- io_wait  out  1  high while a VRAM prefetch is in flight
- vram_addr  out  ADDR_W  VRAM address
- vram_wr  out  1  VRAM write enable (one cycle)
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data; 1-cycle registered latency
- vblank  in  1  one-cycle pulse at start of vertical blank
- mode  out  2  0 text, 1 graphics I, 2 graphics II, 3 multicolour
- name_table_addr  out  14  {R2[3:0],10'b0}
- font_addr  out  14  {R4[2:0],11'b0}
- color_table_addr  out  14  {R3,6'b0}
- sprite_attr_addr  out  14  {R5[6:0],7'b0}
- sprite_pat_addr  out  14  {R6[2:0],11'b0}
- fg_color, bg_color  out  4 each  R7[7:4], R7[3:0]
- int_n  out  1  active-low interrupt

Behaviour:
Reset:
- R0–R7 = REG_RESET; address = 0; second-byte flag = 0; latch byte = 0; read buffer = 0; status = 0.
- Outputs: io_dout = 0, io_wait = 0, vram_wr = 0, int_n = 1.

Control write:
- First byte (flag = 0): store io_din in the latch byte; set flag.
- Second byte (flag = 1): clear flag, then decode:
  - bit7 = 1: register write. R[io_din[2:0]] <= latch byte.
  - bit7 = 0: address <= {io_din[5:0], latch byte}.
  - bit7 = 0 and bit6 = 0 (read setup): additionally start a prefetch.

Data write:
- Clear flag; assert vram_wr for one cycle with vram_addr = address and vram_wdata = io_din.
- Read buffer <= io_din; address <= address + 1.

Data read:
- Clear flag; io_dout <= read buffer; start a prefetch.

Control read (status):
- io_dout <= status {F, 5S, C, 5th-sprite[4:0]}; S, C and the sprite number are always 0 in this block.
- Clear F; clear flag.

Prefetch FSM (IDLE -> ISSUE -> WAIT -> IDLE):
- ISSUE: drive vram_addr = address.
- WAIT: capture vram_rdata into the read buffer; address <= address + 1.
- io_wait is high in ISSUE and WAIT.
- Strobes arriving while io_wait = 1 are ignored: no state change, io_dout unchanged.

Address arithmetic:
- Address increment wraps 3FFF -> 0000.
- Register index uses only io_din[2:0]; bits 5:3 are ignored.

Interrupt:
- vblank sets F.
- int_n = ~(F & R1[5]), registered.
- vblank coincident with a status read: the read returns the pre-event F (0), and F ends at 1.

Mode decode (M1 = R1[4], M2 = R1[3], M3 = R0[1]):
- M1 -> 0; M3 -> 2; M2 -> 3; none -> 1.
- Any other combination -> 0.

Write-read ordering:
- Table addresses and mode update the cycle after the second control byte.
- The read buffer after a data write holds the written byte, so an immediate data read returns that byte, not VRAM contents.

Test Plan:
- Reset, then control writes 0x12, 0x82 -> R2 = 0x12; name_table_addr = 0x0800; flag = 0.
- Control 0x00, 0x40, then data writes 0xAA, 0x55 -> VRAM[0000] = AA, VRAM[0001] = 55; address = 0002; two vram_wr pulses.
- VRAM[3FFF] = 0x5A, VRAM[0000] = 0xC3; control 0xFF, 0x3F (read setup) -> io_wait high for 2 cycles; first data read returns 5A; second returns C3; address wraps to 0001.
- R1 = 0x20; pulse vblank -> int_n = 0; status read returns 0x80, int_n = 1 next cycle; second status read returns 0x00.
- Control 0x07 only, then status read, then control 0x00, 0x40 -> flag was cleared, so 0x00/0x40 act as a fresh pair; the address is set to 0000 (write setup), no register is written, and R0 = 0x00.
- Data read issued while io_wait = 1 -> ignored: io_dout and address unchanged. Reset asserted in WAIT -> FSM returns to IDLE, read buffer = 0, address = 0.

Source files
------------

// File: rtl/vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdp_port_ctrl
// Description : CPU-side port controller for a TMS9918-style VDP.
//               Decodes data (0x98) and control (0x99) port strobes,
//               sequences CPU accesses to VRAM (address latch,
//               auto-increment, read-ahead buffer), holds registers R0..R7
//               and drives mode, table bases, colours and interrupt.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               io_port/io_wr/io_rd - port select and one-cycle strobes
//               io_din/io_dout      - CPU write / registered read data
//               io_wait             - VRAM prefetch in flight
//               vram_*              - VRAM CPU port (1-cycle read latency)
//               vblank              - start-of-vertical-blank pulse
//               mode, *_addr, fg_color, bg_color, int_n - video-side outputs
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_port_ctrl #(
    parameter int          ADDR_W    = 14,
    parameter logic [63:0] REG_RESET = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_port,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [7:0]        io_din,
    output logic [7:0]        io_dout,
    output logic              io_wait,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    input  logic              vblank,
    output logic [1:0]        mode,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       font_addr,
    output logic [13:0]       color_table_addr,
    output logic [13:0]       sprite_attr_addr,
    output logic [13:0]       sprite_pat_addr,
    output logic [3:0]        fg_color,
    output logic [3:0]        bg_color,
    output logic              int_n
);

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0][7:0]   r_regs;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_flag;
    logic [7:0]        r_latch;
    logic [7:0]        r_rbuf;
    logic              r_f;
    logic [7:0]        r_dout;
    logic              r_vram_wr;
    logic [7:0]        r_wdata;
    logic              r_int_n;

    // Strobes are only honoured while no prefetch is in flight.
    logic w_accept;
    logic w_ctrl_wr;
    logic w_ctrl_rd;
    logic w_data_wr;
    logic w_data_rd;
    logic w_reg_wr;
    logic w_f_next;
    logic w_r1b5_next;
    logic [ADDR_W-1:0] w_setup_addr;
    logic w_m1;
    logic w_m2;
    logic w_m3;
    logic w_unused;

    assign w_accept  = (r_state == ST_IDLE);
    // A simultaneous write and read strobe is treated as a write.
    assign w_ctrl_wr = w_accept & io_wr & io_port;
    assign w_data_wr = w_accept & io_wr & ~io_port;
    assign w_ctrl_rd = w_accept & io_rd & ~io_wr & io_port;
    assign w_data_rd = w_accept & io_rd & ~io_wr & ~io_port;

    assign w_reg_wr     = w_ctrl_wr & r_flag & io_din[7];
    assign w_setup_addr = ADDR_W'({io_din[5:0], r_latch});

    // vblank wins over a coincident status read, so F is never lost.
    assign w_f_next    = vblank | (r_f & ~w_ctrl_rd);
    assign w_r1b5_next = (w_reg_wr && io_din[2:0] == 3'd1) ? r_latch[5] : r_regs[1][5];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_regs    <= REG_RESET;
            r_addr    <= '0;
            r_wr_addr <= '0;
            r_flag    <= 1'b0;
            r_latch   <= 8'h00;
            r_rbuf    <= 8'h00;
            r_f       <= 1'b0;
            r_dout    <= 8'h00;
            r_vram_wr <= 1'b0;
            r_wdata   <= 8'h00;
            r_int_n   <= 1'b1;
        end else begin
            r_vram_wr <= 1'b0;

            case (r_state)
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    // VRAM data for the address driven in ISSUE is valid now.
                    r_rbuf  <= vram_rdata;
                    r_addr  <= r_addr + c_ADDR_ONE;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // The strobe branches below can only fire in IDLE, so they never
            // collide with the WAIT-state updates above.
            if (w_ctrl_wr) begin
                if (!r_flag) begin
                    r_latch <= io_din;
                    r_flag  <= 1'b1;
                end else begin
                    r_flag <= 1'b0;
                    if (io_din[7]) begin
                        r_regs[io_din[2:0]] <= r_latch;
                    end else begin
                        r_addr <= w_setup_addr;
                        if (!io_din[6]) begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
            end

            if (w_data_wr) begin
                r_flag    <= 1'b0;
                r_vram_wr <= 1'b1;
                r_wr_addr <= r_addr;
                r_wdata   <= io_din;
                // Read-ahead buffer mirrors the written byte.
                r_rbuf    <= io_din;
                r_addr    <= r_addr + c_ADDR_ONE;
            end

            if (w_data_rd) begin
                r_flag  <= 1'b0;
                r_dout  <= r_rbuf;
                r_state <= ST_ISSUE;
            end

            if (w_ctrl_rd) begin
                r_flag <= 1'b0;
                r_dout <= {r_f, 7'b0};
            end

            r_f     <= w_f_next;
            r_int_n <= ~(w_f_next & w_r1b5_next);
        end
    end

    assign io_dout    = r_dout;
    assign io_wait    = (r_state != ST_IDLE);
    assign vram_wr    = r_vram_wr;
    assign vram_wdata = r_wdata;
    // Write address is held for the pulse; otherwise the live address
    // (which is what the prefetch drives during ISSUE).
    assign vram_addr  = r_vram_wr ? r_wr_addr : r_addr;
    assign int_n      = r_int_n;

    assign w_m1 = r_regs[1][4];
    assign w_m2 = r_regs[1][3];
    assign w_m3 = r_regs[0][1];

    always_comb begin
        mode = 2'd0;
        case ({w_m1, w_m2, w_m3})
            3'b000:  mode = 2'd1;
            3'b100:  mode = 2'd0;
            3'b001:  mode = 2'd2;
            3'b010:  mode = 2'd3;
            default: mode = 2'd0;
        endcase
    end

    assign name_table_addr  = {r_regs[2][3:0], 10'b0};
    assign color_table_addr = {r_regs[3], 6'b0};
    assign font_addr        = {r_regs[4][2:0], 11'b0};
    assign sprite_attr_addr = {r_regs[5][6:0], 7'b0};
    assign sprite_pat_addr  = {r_regs[6][2:0], 11'b0};
    assign fg_color         = r_regs[7][7:4];
    assign bg_color         = r_regs[7][3:0];

    // Register bits with no consumer in this block.
    assign w_unused = ^r_regs;

endmodule
`default_nettype wire

// File: tb/tb_vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_port_ctrl
// Description : Self-checking bench for vdp_port_ctrl with a VRAM model and
//               scoreboard queues for CPU reads and VRAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_port, io_wr, io_rd;
    logic [7:0]  io_din;
    logic [7:0]  io_dout;
    logic        io_wait;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        vblank;
    logic [1:0]  mode;
    logic [13:0] name_table_addr, font_addr, color_table_addr;
    logic [13:0] sprite_attr_addr, sprite_pat_addr;
    logic [3:0]  fg_color, bg_color;
    logic        int_n;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr_pulses = 0;

    typedef struct packed {
        logic [13:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0] rd_q[$];
    wr_t        wr_q[$];
    logic [7:0] mem [0:16383];

    vdp_port_ctrl #(.ADDR_W(14), .REG_RESET(64'h0)) dut (
        .clk(clk), .reset(reset),
        .io_port(io_port), .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din),
        .io_dout(io_dout), .io_wait(io_wait),
        .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata), .vblank(vblank),
        .mode(mode), .name_table_addr(name_table_addr), .font_addr(font_addr),
        .color_table_addr(color_table_addr), .sprite_attr_addr(sprite_attr_addr),
        .sprite_pat_addr(sprite_pat_addr), .fg_color(fg_color), .bg_color(bg_color),
        .int_n(int_n)
    );

    always #5 clk = ~clk;

    // VRAM model: synchronous write, 1-cycle registered read.
    always @(posedge clk) begin
        if (vram_wr) begin
            mem[vram_addr] <= vram_wdata;
            n_wr_pulses <= n_wr_pulses + 1;
        end
        vram_rdata <= mem[vram_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic strobe(input logic port, input logic wr, input logic rd, input logic [7:0] din);
        io_port = port; io_wr = wr; io_rd = rd; io_din = din;
        @(posedge clk); #1;
        io_wr = 1'b0; io_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (io_wait === 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        n_checks++; if (io_dout !== 8'h00) $display("FAIL reset_dout got %h want 00", io_dout); else n_pass++;
        n_checks++; if (io_wait !== 1'b0) $display("FAIL reset_wait got %b want 0", io_wait); else n_pass++;
        n_checks++; if (vram_wr !== 1'b0) $display("FAIL reset_vram_wr got %b want 0", vram_wr); else n_pass++;
        n_checks++; if (int_n !== 1'b1) $display("FAIL reset_int_n got %b want 1", int_n); else n_pass++;
        n_checks++; if (vram_addr !== 14'h0) $display("FAIL reset_addr got %h want 0000", vram_addr); else n_pass++;
        n_checks++; if (mode !== 2'd1) $display("FAIL reset_mode got %0d want 1", mode); else n_pass++;
    endtask

    task automatic test_reg_write;
        strobe(1, 1, 0, 8'h12); strobe(1, 1, 0, 8'h82);
        n_checks++; if (name_table_addr !== 14'h0800) $display("FAIL name_table got %h want 0800", name_table_addr); else n_pass++;
        strobe(1, 1, 0, 8'h05); strobe(1, 1, 0, 8'h84);
        n_checks++; if (font_addr !== 14'h2800) $display("FAIL font_addr got %h want 2800", font_addr); else n_pass++;
        strobe(1, 1, 0, 8'hFF); strobe(1, 1, 0, 8'h83);
        n_checks++; if (color_table_addr !== 14'h3FC0) $display("FAIL color_table got %h want 3fc0", color_table_addr); else n_pass++;
        strobe(1, 1, 0, 8'hFF); strobe(1, 1, 0, 8'h85);
        n_checks++; if (sprite_attr_addr !== 14'h3F80) $display("FAIL sprite_attr got %h want 3f80", sprite_attr_addr); else n_pass++;
        // Index bits 5:3 set: must still land in R6.
        strobe(1, 1, 0, 8'h3B); strobe(1, 1, 0, 8'hBE);
        n_checks++; if (sprite_pat_addr !== 14'h1800) $display("FAIL sprite_pat got %h want 1800", sprite_pat_addr); else n_pass++;
        strobe(1, 1, 0, 8'hA5); strobe(1, 1, 0, 8'h87);
        n_checks++; if ({fg_color, bg_color} !== 8'hA5) $display("FAIL colors got %h want a5", {fg_color, bg_color}); else n_pass++;
    endtask

    task automatic test_data_write;
        wr_t w;
        logic [7:0] e;
        int n;
        n_wr_pulses = 0;
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h40);
        wr_q.push_back({14'h0000, 8'hAA});
        strobe(0, 1, 0, 8'hAA);
        w = wr_q.pop_front();
        n_checks++; if (vram_wr !== 1'b1 || vram_addr !== w.a || vram_wdata !== w.d)
            $display("FAIL wr0 got wr=%b %h/%h want 1 %h/%h", vram_wr, vram_addr, vram_wdata, w.a, w.d); else n_pass++;
        wr_q.push_back({14'h0001, 8'h55});
        strobe(0, 1, 0, 8'h55);
        w = wr_q.pop_front();
        n_checks++; if (vram_wr !== 1'b1 || vram_addr !== w.a || vram_wdata !== w.d)
            $display("FAIL wr1 got wr=%b %h/%h want 1 %h/%h", vram_wr, vram_addr, vram_wdata, w.a, w.d); else n_pass++;
        idle(1);
        n_checks++; if (vram_wr !== 1'b0 || vram_addr !== 14'h0002) $display("FAIL wr_after got wr=%b addr=%h want 0 0002", vram_wr, vram_addr); else n_pass++;
        n_checks++; if (mem[0] !== 8'hAA || mem[1] !== 8'h55) $display("FAIL wr_mem got %h %h want aa 55", mem[0], mem[1]); else n_pass++;
        n_checks++; if (n_wr_pulses !== 2) $display("FAIL wr_pulses got %0d want 2", n_wr_pulses); else n_pass++;
        // Read right after a write returns the written byte.
        rd_q.push_back(8'h55);
        strobe(0, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL wr_then_rd got %h want %h", io_dout, e); else n_pass++;
        wait_idle(n);
    endtask

    task automatic test_read_prefetch;
        logic [7:0] e;
        int n;
        mem[14'h3FFF] = 8'h5A;
        mem[14'h0000] = 8'hC3;
        strobe(1, 1, 0, 8'hFF); strobe(1, 1, 0, 8'h3F);
        n_checks++; if (io_wait !== 1'b1 || vram_addr !== 14'h3FFF) $display("FAIL pf_issue got wait=%b addr=%h want 1 3fff", io_wait, vram_addr); else n_pass++;
        wait_idle(n);
        n_checks++; if (n !== 2) $display("FAIL pf_wait_cycles got %0d want 2", n); else n_pass++;
        rd_q.push_back(8'h5A);
        strobe(0, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL pf_rd0 got %h want %h", io_dout, e); else n_pass++;
        wait_idle(n);
        n_checks++; if (vram_addr !== 14'h0001) $display("FAIL pf_wrap got %h want 0001", vram_addr); else n_pass++;
        rd_q.push_back(8'hC3);
        strobe(0, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL pf_rd1 got %h want %h", io_dout, e); else n_pass++;
        wait_idle(n);
    endtask

    task automatic test_interrupt;
        logic [7:0] e;
        strobe(1, 1, 0, 8'h20); strobe(1, 1, 0, 8'h81);
        idle(1);
        n_checks++; if (int_n !== 1'b1) $display("FAIL irq_idle got %b want 1", int_n); else n_pass++;
        vblank = 1'b1; idle(1); vblank = 1'b0;
        idle(1);
        n_checks++; if (int_n !== 1'b0) $display("FAIL irq_assert got %b want 0", int_n); else n_pass++;
        rd_q.push_back(8'h80);
        strobe(1, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL status0 got %h want %h", io_dout, e); else n_pass++;
        idle(1);
        n_checks++; if (int_n !== 1'b1) $display("FAIL irq_clear got %b want 1", int_n); else n_pass++;
        rd_q.push_back(8'h00);
        strobe(1, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL status1 got %h want %h", io_dout, e); else n_pass++;
        // vblank coincident with status read: pre-event F returned, F stays set.
        rd_q.push_back(8'h00);
        vblank = 1'b1;
        strobe(1, 0, 1, 8'h00);
        vblank = 1'b0;
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL status_coinc got %h want %h", io_dout, e); else n_pass++;
        idle(1);
        n_checks++; if (int_n !== 1'b0) $display("FAIL irq_coinc got %b want 0", int_n); else n_pass++;
        rd_q.push_back(8'h80);
        strobe(1, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL status_after got %h want %h", io_dout, e); else n_pass++;
    endtask

    task automatic test_flag_clear;
        logic [7:0] e;
        strobe(1, 1, 0, 8'h07);
        rd_q.push_back(8'h00);
        strobe(1, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL flag_status got %h want %h", io_dout, e); else n_pass++;
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h40);
        n_checks++; if (vram_addr !== 14'h0000 || io_wait !== 1'b0) $display("FAIL flag_pair got addr=%h wait=%b want 0000 0", vram_addr, io_wait); else n_pass++;
        n_checks++; if (mode !== 2'd1) $display("FAIL flag_r0 got mode %0d want 1", mode); else n_pass++;
    endtask

    task automatic test_mode;
        strobe(1, 1, 0, 8'h10); strobe(1, 1, 0, 8'h81);
        n_checks++; if (mode !== 2'd0) $display("FAIL mode_m1 got %0d want 0", mode); else n_pass++;
        strobe(1, 1, 0, 8'h08); strobe(1, 1, 0, 8'h81);
        n_checks++; if (mode !== 2'd3) $display("FAIL mode_m2 got %0d want 3", mode); else n_pass++;
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h81);
        strobe(1, 1, 0, 8'h02); strobe(1, 1, 0, 8'h80);
        n_checks++; if (mode !== 2'd2) $display("FAIL mode_m3 got %0d want 2", mode); else n_pass++;
        strobe(1, 1, 0, 8'h18); strobe(1, 1, 0, 8'h81);
        n_checks++; if (mode !== 2'd0) $display("FAIL mode_combo got %0d want 0", mode); else n_pass++;
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h80);
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h81);
    endtask

    task automatic test_wait_ignore;
        logic [7:0] e;
        int n;
        rd_q.push_back(8'h00);
        strobe(1, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL ign_status got %h want %h", io_dout, e); else n_pass++;
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h00);
        n_checks++; if (io_wait !== 1'b1) $display("FAIL ign_busy got %b want 1", io_wait); else n_pass++;
        strobe(0, 0, 1, 8'h00);
        n_checks++; if (io_dout !== 8'h00) $display("FAIL ign_dout got %h want 00", io_dout); else n_pass++;
        wait_idle(n);
        n_checks++; if (n !== 1 || vram_addr !== 14'h0001) $display("FAIL ign_addr got n=%0d addr=%h want 1 0001", n, vram_addr); else n_pass++;
        rd_q.push_back(8'hC3);
        strobe(0, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL ign_rd got %h want %h", io_dout, e); else n_pass++;
        wait_idle(n);
    endtask

    task automatic test_reset_in_wait;
        logic [7:0] e;
        int n;
        strobe(1, 1, 0, 8'h00); strobe(1, 1, 0, 8'h00);
        idle(1);
        n_checks++; if (io_wait !== 1'b1) $display("FAIL rst_wait_state got %b want 1", io_wait); else n_pass++;
        reset = 1'b1; idle(1); reset = 1'b0;
        n_checks++; if (io_wait !== 1'b0 || vram_addr !== 14'h0000) $display("FAIL rst_wait got wait=%b addr=%h want 0 0000", io_wait, vram_addr); else n_pass++;
        n_checks++; if (name_table_addr !== 14'h0000) $display("FAIL rst_regs got %h want 0000", name_table_addr); else n_pass++;
        rd_q.push_back(8'h00);
        strobe(0, 0, 1, 8'h00);
        e = rd_q.pop_front();
        n_checks++; if (io_dout !== e) $display("FAIL rst_rbuf got %h want %h", io_dout, e); else n_pass++;
        wait_idle(n);
    endtask

    initial begin
        reset = 1'b1; io_port = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_din = 8'h00; vblank = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        test_reset();
        test_reg_write();
        test_data_write();
        test_read_prefetch();
        test_interrupt();
        test_flag_clear();
        test_mode();
        test_wait_ignore();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
